adaptive_threshold_sequencer: RTL and testbench
===============================================

Name: adaptive_threshold_sequencer

Overview:
- Top-level phase controller for the adaptive-thresholding pipeline.
- Holds box_filter in reset until started, then releases it and waits for its `finished`.
- After box_filter finishes, it takes over the input-ROM read port. It scans every pixel, reads the input ROM and middle RAM in parallel, compares each pixel against its local mean plus an offset, and writes a binary pixel to the output RAM.
- Sits between box_filter, input_rom_reader, middle_ram_controller and the output RAM.

Parameters:
- WIDTH_BITS, 7, column address width; image width = 2**WIDTH_BITS.
- HEIGHT_BITS, 7, row address width; image height = 2**HEIGHT_BITS.

Ports:
- clock  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- iStart  in  1  start request; sampled only in IDLE or DONE.
- iOffset  in  8  threshold offset C; sampled into a register on the PREP cycle.
- oBusy  out  1  high in PREP, BOX, THRESH, FLUSH.
- oDone  out  1  high in DONE only.
- oBoxReset  out  1  drives box_filter reset.
- iBoxFinished  in  1  box_filter finished.
- iBoxImageCol  in  WIDTH_BITS  box_filter ROM column request.
- iBoxImageRow  in  HEIGHT_BITS  box_filter ROM row request.
- oImageCol  out  WIDTH_BITS  muxed input-ROM column.
- oImageRow  out  HEIGHT_BITS  muxed input-ROM row.
- iImageData  in  8  input-ROM data; 1-cycle registered read latency.
- oMidRdCol  out  WIDTH_BITS  middle-RAM read column.
- oMidRdRow  out  HEIGHT_BITS  middle-RAM read row.
- iMidRdData  in  8  middle-RAM data (local mean); 1-cycle latency.
- oOutCol  out  WIDTH_BITS  output-RAM write column.
- oOutRow  out  HEIGHT_BITS  output-RAM write row.
- oOutData  out  8  binary pixel, 8'hFF or 8'h00.
- oOutWren  out  1  output-RAM write enable.

Behaviour:
- Reset: state=IDLE, oBoxReset=1, oBusy=0, oDone=0, oOutWren=0, all address/data outputs 0, scan counters 0, offset register 0.
  - Reset mid-operation aborts immediately to these values.
  - No further output-RAM writes occur after reset.
- States and transitions:
  - IDLE: oBoxReset=1. On iStart → PREP.
  - PREP: one cycle, oBoxReset=1. Latch iOffset. → BOX.
    - PREP guarantees at least one reset cycle, so a stale `finished` from a previous run is cleared.
  - BOX: oBoxReset=0. When iBoxFinished=1 → THRESH. Scan counters are cleared on entry.
  - THRESH: one pixel address issued per cycle, raster order, column fastest.
    - oImageCol/Row = oMidRdCol/Row = scan counters.
    - When the address (W-1, H-1) has been issued → FLUSH.
  - FLUSH: one cycle to write the final pixel. → DONE.
  - DONE: oDone=1, oBoxReset=1. On iStart → PREP (rerun).
- iStart is ignored in PREP, BOX, THRESH and FLUSH.
- ROM port mux:
  - PREP and BOX: oImageCol/Row = iBoxImageCol/Row, combinational passthrough (box_filter's latency is unchanged).
  - THRESH: scan counters.
  - Otherwise: 0.
- oMidRdCol/Row are driven by the scan counters in THRESH; 0 otherwise.
- Pipeline:
  - Address issued in cycle k → data valid in cycle k+1.
  - Registered copies of the address and a valid bit align the write with the data.
  - oOutWren=1 in cycle k+1 for every issued address, i.e. from the 2nd THRESH cycle through FLUSH inclusive.
  - oOutCol/Row are the delayed address.
- Arithmetic:
  - sum = {1'b0,iImageData} + {1'b0,offset}, 9 bits, no saturation.
  - oOutData = (sum >= {1'b0,iMidRdData}) ? 8'hFF : 8'h00.
  - oOutData is combinational from the read data, valid while oOutWren=1.
- Scan counters:
  - Column wraps W-1 → 0 and increments the row.
  - The last address is not followed by a wrap into row 0.
- Timing: THRESH lasts W*H cycles, FLUSH 1 cycle. Exactly W*H writes per run, each address written once.
- iBoxFinished is ignored outside BOX.
- If iBoxFinished is already 1 on the first BOX cycle, the sequencer still transitions; the PREP reset guarantees this is a genuine completion.

Decomposition:
- Package adaptive_threshold_pkg:
  - State encoding localparams: IDLE, PREP, BOX, THRESH, FLUSH, DONE.
  - BIN_HIGH=8'hFF, BIN_LOW=8'h00.
- One natural sub-module, raster_scan_counter: col/row counters with clear, enable and last-pixel flag, parameterised by WIDTH_BITS/HEIGHT_BITS.
- Compare/pipeline logic stays in the top.

Test Plan (WIDTH_BITS=HEIGHT_BITS=2, 16 pixels, behavioural 1-cycle ROM/RAM models):
- Reset then idle 5 cycles, no iStart → oBoxReset=1, oBusy=0, oDone=0, oOutWren never high.
- iStart pulse, iOffset=10; iBoxFinished raised 20 cycles after oBoxReset falls → PREP 1 cycle, BOX 20+ cycles, oImageCol/Row track iBoxImageCol/Row exactly in BOX.
- THRESH scan, ROM pixel=100 everywhere, mean=109 at (1,2) and 111 at (2,1) → output (1,2)=8'hFF, (2,1)=8'h00; exactly 16 writes, raster order, first write one cycle after THRESH entry, oDone one cycle after FLUSH.
- Overflow: pixel=250, offset=10, mean=255 → sum=260 ≥ 255 → 8'hFF (no 8-bit wrap).
- Reset asserted mid-THRESH (after 7 writes) → next cycle oOutWren=0, oBoxReset=1, state IDLE; a new iStart reruns with a full 16 writes.
- iStart pulsed during BOX and THRESH → ignored; iStart in DONE → one PREP cycle with oBoxReset=1, then a second complete run.

Source files
------------

// File: rtl/adaptive_threshold_pkg.sv
// adaptive_threshold_pkg: shared state encoding and binary pixel levels for the thresholding sequencer
package adaptive_threshold_pkg;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PREP   = 3'd1,
        BOX    = 3'd2,
        THRESH = 3'd3,
        FLUSH  = 3'd4,
        DONE   = 3'd5
    } state_e;
    localparam logic [7:0] BIN_HIGH = 8'hFF;
    localparam logic [7:0] BIN_LOW  = 8'h00;
endpackage

// File: rtl/raster_scan_counter.sv
// raster_scan_counter: column-fastest raster address counter that parks on the last pixel
module raster_scan_counter #(
    parameter int WIDTH_BITS  = 7,
    parameter int HEIGHT_BITS = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear_i,
    input  logic                   en_i,
    output logic [WIDTH_BITS-1:0]  col_o,
    output logic [HEIGHT_BITS-1:0] row_o,
    output logic                   last_o
);
    logic [WIDTH_BITS-1:0]  col_q, col_d;
    logic [HEIGHT_BITS-1:0] row_q, row_d;
    assign last_o = (&col_q) && (&row_q);
    assign col_o  = col_q;
    assign row_o  = row_q;
    // Holding at the last pixel avoids a spurious wrap back to (0,0).
    always_comb begin
        col_d = (en_i && !last_o) ? col_q + 1'b1 : col_q;
        row_d = (en_i && !last_o && (&col_q)) ? row_q + 1'b1 : row_q;
    end
    always_ff @(posedge clock) begin
        if (reset || clear_i) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end
endmodule

// File: rtl/adaptive_threshold_sequencer.sv
// adaptive_threshold_sequencer: runs box_filter, then scans every pixel and writes
// a binary result comparing pixel+offset against the local mean.
module adaptive_threshold_sequencer
    import adaptive_threshold_pkg::*;
#(
    parameter int WIDTH_BITS  = 7,
    parameter int HEIGHT_BITS = 7
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   iStart,
    input  logic [7:0]             iOffset,
    output logic                   oBusy,
    output logic                   oDone,
    output logic                   oBoxReset,
    input  logic                   iBoxFinished,
    input  logic [WIDTH_BITS-1:0]  iBoxImageCol,
    input  logic [HEIGHT_BITS-1:0] iBoxImageRow,
    output logic [WIDTH_BITS-1:0]  oImageCol,
    output logic [HEIGHT_BITS-1:0] oImageRow,
    input  logic [7:0]             iImageData,
    output logic [WIDTH_BITS-1:0]  oMidRdCol,
    output logic [HEIGHT_BITS-1:0] oMidRdRow,
    input  logic [7:0]             iMidRdData,
    output logic [WIDTH_BITS-1:0]  oOutCol,
    output logic [HEIGHT_BITS-1:0] oOutRow,
    output logic [7:0]             oOutData,
    output logic                   oOutWren
);
    state_e                 state_q, state_d;
    logic [7:0]             offset_q, offset_d;
    logic                   vld_q, vld_d;
    logic [WIDTH_BITS-1:0]  out_col_q, out_col_d, scan_col;
    logic [HEIGHT_BITS-1:0] out_row_q, out_row_d, scan_row;
    logic                   scan_last, in_thresh, in_box_phase;
    logic [8:0]             sum;

    assign in_thresh    = (state_q == THRESH);
    assign in_box_phase = (state_q == PREP) || (state_q == BOX);

    raster_scan_counter #(
        .WIDTH_BITS (WIDTH_BITS),
        .HEIGHT_BITS(HEIGHT_BITS)
    ) u_scan (
        .clock  (clock),
        .reset  (reset),
        .clear_i(!in_thresh),
        .en_i   (in_thresh),
        .col_o  (scan_col),
        .row_o  (scan_row),
        .last_o (scan_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = iStart ? PREP : IDLE;
            PREP:    state_d = BOX;
            BOX:     state_d = iBoxFinished ? THRESH : BOX;
            THRESH:  state_d = scan_last ? FLUSH : THRESH;
            FLUSH:   state_d = DONE;
            DONE:    state_d = iStart ? PREP : DONE;
            default: state_d = IDLE;
        endcase
        offset_d  = (state_q == PREP) ? iOffset : offset_q;
        vld_d     = in_thresh;
        out_col_d = in_thresh ? scan_col : out_col_q;
        out_row_d = in_thresh ? scan_row : out_row_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            offset_q  <= '0;
            vld_q     <= 1'b0;
            out_col_q <= '0;
            out_row_q <= '0;
        end else begin
            state_q   <= state_d;
            offset_q  <= offset_d;
            vld_q     <= vld_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
        end
    end

    // The 9-bit sum keeps pixel+offset from wrapping past 255.
    assign sum       = {1'b0, iImageData} + {1'b0, offset_q};
    assign oOutData  = (vld_q && (sum >= {1'b0, iMidRdData})) ? BIN_HIGH : BIN_LOW;
    assign oOutWren  = vld_q;
    assign oOutCol   = out_col_q;
    assign oOutRow   = out_row_q;
    assign oBusy     = in_box_phase || in_thresh || (state_q == FLUSH);
    assign oDone     = (state_q == DONE);
    assign oBoxReset = (state_q == IDLE) || (state_q == PREP) || (state_q == DONE);
    assign oImageCol = in_box_phase ? iBoxImageCol : (in_thresh ? scan_col : '0);
    assign oImageRow = in_box_phase ? iBoxImageRow : (in_thresh ? scan_row : '0);
    assign oMidRdCol = in_thresh ? scan_col : '0;
    assign oMidRdRow = in_thresh ? scan_row : '0;
endmodule

// File: tb/tb_adaptive_threshold_sequencer.sv
// tb_adaptive_threshold_sequencer: randomized scenarios scored against a per-pixel threshold model
module tb_adaptive_threshold_sequencer;
    localparam int WB = 2;
    localparam int HB = 2;
    localparam int W  = 1 << WB;
    localparam int H  = 1 << HB;
    localparam int N  = W * H;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          iStart = 1'b0;
    logic [7:0]    iOffset = '0;
    logic          oBusy, oDone, oBoxReset, oOutWren;
    logic          iBoxFinished = 1'b0;
    logic [WB-1:0] iBoxImageCol = '0;
    logic [HB-1:0] iBoxImageRow = '0;
    logic [WB-1:0] oImageCol, oMidRdCol, oOutCol;
    logic [HB-1:0] oImageRow, oMidRdRow, oOutRow;
    logic [7:0]    iImageData = '0;
    logic [7:0]    iMidRdData = '0;
    logic [7:0]    oOutData;

    logic [7:0] rom [N];
    logic [7:0] mean [N];
    int wcol[$], wrow[$], wdat[$];
    int checks = 0;
    int errors = 0;

    adaptive_threshold_sequencer #(.WIDTH_BITS(WB), .HEIGHT_BITS(HB)) dut (
        .clock(clock), .reset(reset), .iStart(iStart), .iOffset(iOffset),
        .oBusy(oBusy), .oDone(oDone), .oBoxReset(oBoxReset),
        .iBoxFinished(iBoxFinished), .iBoxImageCol(iBoxImageCol), .iBoxImageRow(iBoxImageRow),
        .oImageCol(oImageCol), .oImageRow(oImageRow), .iImageData(iImageData),
        .oMidRdCol(oMidRdCol), .oMidRdRow(oMidRdRow), .iMidRdData(iMidRdData),
        .oOutCol(oOutCol), .oOutRow(oOutRow), .oOutData(oOutData), .oOutWren(oOutWren)
    );

    always #5 clock = ~clock;

    // One-cycle registered ROM and middle-RAM models.
    always @(posedge clock) begin
        iImageData <= rom[int'(oImageRow) * W + int'(oImageCol)];
        iMidRdData <= mean[int'(oMidRdRow) * W + int'(oMidRdCol)];
    end

    always @(negedge clock) begin
        if (oOutWren) begin
            wcol.push_back(int'(oOutCol));
            wrow.push_back(int'(oOutRow));
            wdat.push_back(int'(oOutData));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic clear_writes();
        wcol.delete();
        wrow.delete();
        wdat.delete();
    endtask

    task automatic do_run(input logic [7:0] off, input bit noisy, input int box_n);
        clear_writes();
        iStart = 1'b1;
        iOffset = off;
        tick();
        iStart = 1'b0;
        checks++;
        if (oBusy !== 1'b1 || oBoxReset !== 1'b1 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL prep_state: busy=%b boxrst=%b done=%b required 1 1 0", oBusy, oBoxReset, oDone);
        end
        tick();
        iOffset = 8'($urandom);
        checks++;
        if (oBoxReset !== 1'b0 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL box_entry: boxrst=%b busy=%b required 0 1", oBoxReset, oBusy);
        end
        for (int i = 0; i < box_n; i++) begin
            iBoxImageCol = WB'($urandom);
            iBoxImageRow = HB'($urandom);
            if (noisy) iStart = 1'($urandom);
            #1;
            checks++;
            if (oImageCol !== iBoxImageCol || oImageRow !== iBoxImageRow || oBoxReset !== 1'b0) begin
                errors++;
                $display("FAIL box_passthru: col=%0d row=%0d boxrst=%b required %0d %0d 0",
                         oImageCol, oImageRow, oBoxReset, iBoxImageCol, iBoxImageRow);
            end
            tick();
        end
        iStart = 1'b0;
        iBoxFinished = 1'b1;
        tick();
        iBoxFinished = 1'b0;
        checks++;
        if (oImageCol !== 0 || oImageRow !== 0 || oMidRdCol !== 0 || oMidRdRow !== 0 || oOutWren !== 1'b0 || oBusy !== 1'b1) begin
            errors++;
            $display("FAIL thresh_entry: addr=(%0d,%0d) mid=(%0d,%0d) wren=%b busy=%b required (0,0) (0,0) 0 1",
                     oImageCol, oImageRow, oMidRdCol, oMidRdRow, oOutWren, oBusy);
        end
        for (int c = 1; c <= N; c++) begin
            if (noisy) begin
                iStart = 1'($urandom);
                iBoxFinished = 1'($urandom);
            end
            tick();
            checks++;
            if (oOutWren !== 1'b1 || oBusy !== 1'b1 || oDone !== 1'b0) begin
                errors++;
                $display("FAIL scan_cycle%0d: wren=%b busy=%b done=%b required 1 1 0", c, oOutWren, oBusy, oDone);
            end
            if (c < N) begin
                checks++;
                if (int'(oImageCol) != c % W || int'(oImageRow) != c / W || oMidRdCol !== oImageCol || oMidRdRow !== oImageRow) begin
                    errors++;
                    $display("FAIL scan_addr%0d: rom=(%0d,%0d) mid=(%0d,%0d) required (%0d,%0d)",
                             c, oImageCol, oImageRow, oMidRdCol, oMidRdRow, c % W, c / W);
                end
            end
        end
        iStart = 1'b0;
        iBoxFinished = 1'b0;
        tick();
        checks++;
        if (oDone !== 1'b1 || oBusy !== 1'b0 || oOutWren !== 1'b0 || oBoxReset !== 1'b1) begin
            errors++;
            $display("FAIL done_state: done=%b busy=%b wren=%b boxrst=%b required 1 0 0 1", oDone, oBusy, oOutWren, oBoxReset);
        end
        checks++;
        if (wdat.size() != N) begin
            errors++;
            $display("FAIL write_count: got %0d required %0d", wdat.size(), N);
        end else begin
            for (int k = 0; k < N; k++) begin
                int exp_d;
                exp_d = (int'(rom[k]) + int'(off) >= int'(mean[k])) ? 255 : 0;
                checks++;
                if (wcol[k] != k % W || wrow[k] != k / W || wdat[k] != exp_d) begin
                    errors++;
                    $display("FAIL write%0d: (%0d,%0d)=%0d required (%0d,%0d)=%0d",
                             k, wcol[k], wrow[k], wdat[k], k % W, k / W, exp_d);
                end
            end
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) begin
            rom[i] = 8'($urandom);
            mean[i] = 8'($urandom);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        clear_writes();
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (oBoxReset !== 1'b1 || oBusy !== 1'b0 || oDone !== 1'b0 || oOutWren !== 1'b0 ||
                oImageCol !== 0 || oOutCol !== 0 || oOutData !== 8'h00) begin
                errors++;
                $display("FAIL reset_idle%0d: boxrst=%b busy=%b done=%b wren=%b imgcol=%0d outcol=%0d data=%0h required 1 0 0 0 0 0 0",
                         i, oBoxReset, oBusy, oDone, oOutWren, oImageCol, oOutCol, oOutData);
            end
        end
        checks++;
        if (wdat.size() != 0) begin
            errors++;
            $display("FAIL reset_no_writes: got %0d writes required 0", wdat.size());
        end
    endtask

    task automatic test_threshold();
        for (int i = 0; i < N; i++) begin
            rom[i] = 8'd100;
            mean[i] = 8'($urandom_range(90, 130));
        end
        mean[2 * W + 1] = 8'd109;
        mean[1 * W + 2] = 8'd111;
        do_run(8'd10, 1'b0, 20);
        checks++;
        if (wdat.size() == N && (wdat[2 * W + 1] != 255 || wdat[1 * W + 2] != 0)) begin
            errors++;
            $display("FAIL thresh_points: (1,2)=%0d (2,1)=%0d required 255 0", wdat[2 * W + 1], wdat[1 * W + 2]);
        end
    endtask

    task automatic test_overflow();
        fill_random();
        rom[5] = 8'd250;
        mean[5] = 8'd255;
        rom[10] = 8'd250;
        mean[10] = 8'd255;
        do_run(8'd10, 1'b0, 3);
        checks++;
        if (wdat.size() == N && (wdat[5] != 255 || wdat[10] != 255)) begin
            errors++;
            $display("FAIL overflow: pix5=%0d pix10=%0d required 255 255", wdat[5], wdat[10]);
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        fill_random();
        clear_writes();
        iStart = 1'b1;
        iOffset = 8'd33;
        tick();
        iStart = 1'b0;
        repeat (4) tick();
        iBoxFinished = 1'b1;
        tick();
        iBoxFinished = 1'b0;
        guard = 0;
        while (wdat.size() < 7 && guard < 40) begin
            tick();
            guard++;
        end
        checks++;
        if (wdat.size() < 7) begin
            errors++;
            $display("FAIL mid_wait: got %0d writes required 7", wdat.size());
        end
        reset = 1'b1;
        tick();
        checks++;
        if (oOutWren !== 1'b0 || oBoxReset !== 1'b1 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: wren=%b boxrst=%b busy=%b done=%b required 0 1 0 0", oOutWren, oBoxReset, oBusy, oDone);
        end
        reset = 1'b0;
        clear_writes();
        repeat (4) tick();
        checks++;
        if (wdat.size() != 0 || oBusy !== 1'b0 || oDone !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: writes=%0d busy=%b done=%b required 0 0 0", wdat.size(), oBusy, oDone);
        end
        fill_random();
        do_run(8'($urandom), 1'b0, 5);
    endtask

    task automatic test_back_to_back();
        fill_random();
        do_run(8'($urandom), 1'b1, 6);
        fill_random();
        do_run(8'($urandom), 1'b1, 2);
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            rom[i] = '0;
            mean[i] = '0;
        end
        test_reset();
        test_threshold();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
